dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Two-port data-memory arbiter bus: requester ports, memory side and busy.
// The arbiter takes the slave modport; the bench/system drives via master.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p1_req;
  logic        p0_we;
  logic        p1_we;
  logic        p0_size;
  logic        p1_size;
  logic [11:0] p0_addr;
  logic [11:0] p1_addr;
  logic [31:0] p0_wdata;
  logic [31:0] p1_wdata;
  logic        p0_ack;
  logic        p1_ack;
  logic [31:0] p0_rdata;
  logic [31:0] p1_rdata;
  logic [11:0] mem_addr;
  logic [1:0]  mem_we;
  logic [1:0]  mem_re;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we,
    input  p0_size, p1_size, p0_addr, p1_addr,
    input  p0_wdata, p1_wdata, mem_rdata,
    output p0_ack, p1_ack, p0_rdata, p1_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata,
    output busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we,
    output p0_size, p1_size, p0_addr, p1_addr,
    output p0_wdata, p1_wdata, mem_rdata,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, round-robin on ties.
// Define DMEM_ARB_FIXED_PRIO_EN for strict port-0 priority instead.
module dmem_arbiter (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ACCESS, CAPTURE, DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_size;
  logic        r_win;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_mem_we;
  logic [1:0]  r_mem_re;
  logic        r_p0_ack;
  logic        r_p1_ack;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;
  logic        r_busy;

  logic        w_any;
  logic        w_win;
  logic        w_we;
  logic        w_size;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_cap;

  assign w_any = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_win = ~bus.p0_req;
`else
  // r_last = 1 means port 1 was granted last
  logic r_last;
  assign w_win = (bus.p0_req & bus.p1_req) ? ~r_last
                                           : bus.p1_req;
`endif

  assign w_we    = w_win ? bus.p1_we    : bus.p0_we;
  assign w_size  = w_win ? bus.p1_size  : bus.p0_size;
  assign w_addr  = w_win ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata = w_win ? bus.p1_wdata : bus.p0_wdata;
  assign w_cap   = r_size ? bus.mem_rdata
                          : {24'd0, bus.mem_rdata[7:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 1'b0;
      r_win      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_we   <= 2'b00;
      r_mem_re   <= 2'b00;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
      r_busy     <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last     <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= ACCESS;
            r_busy   <= 1'b1;
            r_win    <= w_win;
            r_we     <= w_we;
            r_size   <= w_size;
            r_addr   <= w_addr;
            r_wdata  <= w_size ? w_wdata
                                : {24'd0, w_wdata[7:0]};
            r_mem_we <= !w_we ? 2'b00
                      : (w_size ? 2'b10 : 2'b01);
            r_mem_re <= w_we ? 2'b00
                      : (w_size ? 2'b10 : 2'b01);
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_last   <= w_win;
`endif
          end
        end
        ACCESS: begin
          r_mem_we <= 2'b00;
          r_mem_re <= 2'b00;
          if (r_we) begin
            r_state  <= DONE;
            r_p0_ack <= ~r_win;
            r_p1_ack <= r_win;
          end else begin
            r_state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_state  <= DONE;
          r_p0_ack <= ~r_win;
          r_p1_ack <= r_win;
          if (r_win) r_p1_rdata <= w_cap;
          else       r_p0_rdata <= w_cap;
        end
        DONE: begin
          r_state  <= IDLE;
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.p0_ack    = r_p0_ack;
  assign bus.p1_ack    = r_p1_ack;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: latency, data paths,
// arbitration order, reset abort and mid-transaction req drop.
module tb_dmem_arbiter;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_req    = 1'b0;
    bus.p1_req    = 1'b0;
    bus.p0_we     = 1'b0;
    bus.p1_we     = 1'b0;
    bus.p0_size   = 1'b0;
    bus.p1_size   = 1'b0;
    bus.p0_addr   = '0;
    bus.p1_addr   = '0;
    bus.p0_wdata  = '0;
    bus.p1_wdata  = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mem_rdata = 32'hFFFF_FFFF;
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    checks++;
    if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack got %b%b want 00",
               bus.p0_ack, bus.p1_ack);
    end
    checks++;
    if ({bus.mem_we, bus.mem_re} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobe we %b re %b want 00 00",
               bus.mem_we, bus.mem_re);
    end
    checks++;
    if (bus.mem_addr !== 12'h000 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem addr %h wdata %h want 0 0",
               bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata p0 %h p1 %h want 0 0",
               bus.p0_rdata, bus.p1_rdata);
    end
    reset_n = 1'b1;
    bus.mem_rdata = '0;
    step();
  endtask

  task automatic test_byte_write();
    bus.p0_req   = 1'b1;
    bus.p0_we    = 1'b1;
    bus.p0_size  = 1'b0;
    bus.p0_addr  = 12'h010;
    bus.p0_wdata = 32'h0000_00AA;
    step();
    checks++;
    if (bus.mem_we !== 2'b01 || bus.mem_re !== 2'b00) begin
      errors++;
      $display("FAIL bw_strobe we %b re %b want 01 00",
               bus.mem_we, bus.mem_re);
    end
    checks++;
    if (bus.mem_addr !== 12'h010 || bus.mem_wdata !== 32'hAA) begin
      errors++;
      $display("FAIL bw_bus addr %h wdata %h want 010 000000aa",
               bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL bw_n1 busy %b ack %b want 1 0",
               bus.busy, bus.p0_ack);
    end
    step();
    checks++;
    if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL bw_ack p0 %b p1 %b want 1 0",
               bus.p0_ack, bus.p1_ack);
    end
    checks++;
    if (bus.mem_we !== 2'b00) begin
      errors++;
      $display("FAIL bw_we_done got %b want 00", bus.mem_we);
    end
    bus.p0_req = 1'b0;
    step();
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bw_end ack %b busy %b want 0 0",
               bus.p0_ack, bus.busy);
    end
  endtask

  task automatic test_word_read();
    bus.p0_req  = 1'b1;
    bus.p0_we   = 1'b0;
    bus.p0_size = 1'b1;
    bus.p0_addr = 12'h020;
    step();
    checks++;
    if (bus.mem_re !== 2'b10 || bus.mem_we !== 2'b00 ||
        bus.mem_addr !== 12'h020) begin
      errors++;
      $display("FAIL wr_access re %b we %b addr %h want 10 00 020",
               bus.mem_re, bus.mem_we, bus.mem_addr);
    end
    step();
    bus.mem_rdata = 32'hDEAD_BEEF;
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.mem_re !== 2'b00) begin
      errors++;
      $display("FAIL wr_capture ack %b re %b want 0 00",
               bus.p0_ack, bus.mem_re);
    end
    step();
    checks++;
    if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_ack ack %b rdata %h want 1 deadbeef",
               bus.p0_ack, bus.p0_rdata);
    end
    bus.p0_req    = 1'b0;
    bus.mem_rdata = 32'h5555_5555;
    step();
    step();
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.p0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_hold ack %b rdata %h want 0 deadbeef",
               bus.p0_ack, bus.p0_rdata);
    end
  endtask

  task automatic test_byte_read_p1();
    bus.p1_req  = 1'b1;
    bus.p1_we   = 1'b0;
    bus.p1_size = 1'b0;
    bus.p1_addr = 12'h0C4;
    step();
    checks++;
    if (bus.mem_re !== 2'b01 || bus.mem_addr !== 12'h0C4) begin
      errors++;
      $display("FAIL br_access re %b addr %h want 01 0c4",
               bus.mem_re, bus.mem_addr);
    end
    step();
    bus.mem_rdata = 32'h1234_56C3;
    step();
    checks++;
    if (bus.p1_ack !== 1'b1 || bus.p0_ack !== 1'b0 ||
        bus.p1_rdata !== 32'h0000_00C3) begin
      errors++;
      $display("FAIL br_ack p1 %b p0 %b rdata %h want 1 0 000000c3",
               bus.p1_ack, bus.p0_ack, bus.p1_rdata);
    end
    checks++;
    if (bus.p0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL br_p0_hold got %h want deadbeef", bus.p0_rdata);
    end
    bus.p1_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int exp_port [4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 0, 0};
`else
    exp_port = '{0, 1, 0, 1};
`endif
    bus.p0_req   = 1'b1;
    bus.p1_req   = 1'b1;
    bus.p0_we    = 1'b1;
    bus.p1_we    = 1'b1;
    bus.p0_size  = 1'b1;
    bus.p1_size  = 1'b1;
    bus.p0_addr  = 12'h100;
    bus.p1_addr  = 12'h200;
    bus.p0_wdata = 32'h0000_1111;
    bus.p1_wdata = 32'h0000_2222;
    for (int t = 0; t < 5; t++) begin
      int got;
      int want;
      got  = -1;
      want = (t < 4) ? exp_port[t] : 1;
      if (t == 4) bus.p0_req = 1'b0;
      for (int c = 0; c < 6 && got < 0; c++) begin
        step();
        if (bus.p0_ack && bus.p1_ack) begin
          checks++;
          errors++;
          $display("FAIL rr_dual_ack both acks high at txn %0d", t);
          got = 2;
        end else if (bus.p0_ack) begin
          got = 0;
        end else if (bus.p1_ack) begin
          got = 1;
        end
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rr_order txn %0d got port %0d want %0d",
                 t, got, want);
      end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.p1_req  = 1'b1;
    bus.p1_we   = 1'b0;
    bus.p1_size = 1'b1;
    bus.p1_addr = 12'h0F0;
    step();
    step();
    bus.mem_rdata = 32'hCAFE_F00D;
    reset_n = 1'b0;
    step();
    checks++;
    if (bus.p1_ack !== 1'b0 || bus.busy !== 1'b0 ||
        bus.mem_re !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid ack %b busy %b re %b want 0 0 00",
               bus.p1_ack, bus.busy, bus.mem_re);
    end
    checks++;
    if (bus.p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_rdata got %h want 0", bus.p1_rdata);
    end
    reset_n      = 1'b1;
    bus.p0_req   = 1'b1;
    bus.p0_we    = 1'b1;
    bus.p0_size  = 1'b1;
    bus.p1_we    = 1'b1;
    step();
    checks++;
    if (bus.mem_addr !== bus.p0_addr || bus.mem_we !== 2'b10) begin
      errors++;
      $display("FAIL rst_tie_access addr %h we %b want %h 10",
               bus.mem_addr, bus.mem_we, bus.p0_addr);
    end
    step();
    checks++;
    if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie p0 %b p1 %b want 1 0",
               bus.p0_ack, bus.p1_ack);
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    step();
  endtask

  task automatic test_drop_mid();
    bus.p0_req   = 1'b1;
    bus.p0_we    = 1'b1;
    bus.p0_size  = 1'b1;
    bus.p0_addr  = 12'h3A5;
    bus.p0_wdata = 32'h8765_4321;
    step();
    bus.p0_req = 1'b0;
    checks++;
    if (bus.mem_we !== 2'b10 || bus.mem_wdata !== 32'h8765_4321) begin
      errors++;
      $display("FAIL drop_access we %b wdata %h want 10 87654321",
               bus.mem_we, bus.mem_wdata);
    end
    step();
    checks++;
    if (bus.p0_ack !== 1'b1) begin
      errors++;
      $display("FAIL drop_ack got %b want 1", bus.p0_ack);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle busy %b ack %b want 0 0",
               bus.busy, bus.p0_ack);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 2'b00) begin
      errors++;
      $display("FAIL drop_stay busy %b we %b want 0 00",
               bus.busy, bus.mem_we);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    test_reset();
    test_byte_write();
    test_word_read();
    test_byte_read_p1();
    test_round_robin();
    test_reset_mid();
    test_drop_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
